// File: rtl/tree_feeder_pkg.sv
// tree_feeder_pkg: shared widths and FSM states for the adder-tree feeder
package tree_feeder_pkg;
  localparam int LANES = 8;
  localparam int W_IN = 8;
  localparam int W_SUM = 11;
  localparam int W_CNT = 3;
  typedef enum logic [1:0] {FILL, WAIT, OUT} state_t;
endpackage

// File: rtl/tree_feeder.sv
// tree_feeder: collects eight bytes into lanes, waits out the tree latency, returns the sum
module tree_feeder
  import tree_feeder_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W_IN-1:0]        in_data,
  output logic [LANES*W_IN-1:0]  lane_bus,
  input  logic [W_SUM-1:0]       tree_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W_SUM-1:0]       out_sum
);
  localparam logic [3:0] LATW = 4'(LAT);
  state_t state, nxt;
  logic [W_CNT-1:0] cnt;
  logic [3:0] wcnt;
  logic [W_IN-1:0] lanes [LANES];
  logic acc, last, cap;
  assign in_ready = state == FILL;
  assign out_valid = state == OUT;
  assign acc = in_valid && in_ready;
  assign last = acc && cnt == W_CNT'(LANES - 1);
  assign cap = state == WAIT && wcnt == LATW;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_bus[W_IN*i +: W_IN] = lanes[i];
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FILL;
    else state <= nxt;
  // next state: fill -> wait on eighth byte, wait -> out on capture, out -> fill on handshake
  always_comb begin
    nxt = state;
    nxt = last ? WAIT : cap ? OUT : (state == OUT && out_ready) ? FILL : state;
  end
  // lane capture, latency counter and result register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wcnt <= '0;
      out_sum <= '0;
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
    end else begin
      if (acc) lanes[cnt] <= in_data;
      cnt <= acc ? cnt + 1'b1 : cnt;
      wcnt <= state == WAIT ? wcnt + 4'(wcnt < LATW) : '0;
      out_sum <= cap ? tree_y : out_sum;
    end
endmodule

// File: tb/tb_tree_feeder.sv
// tb_tree_feeder: directed scoreboard bench with a behavioural LAT-stage adder tree
module tb_tree_feeder;
  import tree_feeder_pkg::*;
  localparam int LAT = 3;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_data = 0;
  logic [63:0] lane_bus;
  logic [10:0] tree_y, out_sum, tsum;
  logic [10:0] pipe [LAT];
  logic [10:0] q [$];
  logic [63:0] exp_lanes = 0;
  logic rdy_def = 0;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  tree_feeder #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lane_bus(lane_bus), .tree_y(tree_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  // combinational sum of the eight lanes
  always_comb begin
    tsum = '0;
    for (int i = 0; i < 8; i++) tsum = tsum + 11'(lane_bus[8*i +: 8]);
  end

  // LAT register stages of the downstream tree
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= tsum;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign tree_y = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    #2 rst = 0;
    exp_lanes = '0;
  endtask

  task automatic send(input logic [7:0] base, input logic [7:0] step, input bit gap, input int n);
    int s = 0;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = base + 8'(k) * step;
      if (gap) begin
        in_valid = 0;
        tick();
        chk("gap_rdy", 64'(in_ready), 64'(1));
        chk("gap_lanes", lane_bus, exp_lanes);
      end
      chk("fill_rdy", 64'(in_ready), 64'(1));
      in_valid = 1;
      in_data = b;
      tick();
      exp_lanes[8*k +: 8] = b;
      s += int'(b);
    end
    in_valid = 0;
    chk("lanes", lane_bus, exp_lanes);
    if (n == 8) q.push_back(11'(s));
  endtask

  task automatic collect(input int hold);
    int n = 0;
    logic [10:0] e, s;
    e = q.pop_front();
    chk("wait_rdy", 64'(in_ready), 64'(0));
    while (!out_valid && n < 40) begin
      tick();
      n++;
      chk("wait_lanes", lane_bus, exp_lanes);
    end
    chk("latency", 64'(n), 64'(LAT + 1));
    chk("sum", 64'(out_sum), 64'(e));
    s = out_sum;
    if (hold > 0) begin
      out_ready = 0;
      in_valid = 1;
      in_data = 8'hAA;
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_sum", 64'(out_sum), 64'(s));
        chk("hold_rdy", 64'(in_ready), 64'(0));
      end
    end
    out_ready = 1;
    tick();
    chk("ret_valid", 64'(out_valid), 64'(0));
    chk("ret_rdy", 64'(in_ready), 64'(1));
    chk("no_accept", lane_bus, exp_lanes);
    in_valid = 0;
    out_ready = rdy_def;
  endtask

  initial begin
    in_valid = 1;
    in_data = 8'h55;
    tick();
    tick();
    rst = 0;
    in_valid = 0;
    chk("rst_rdy", 64'(in_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(out_sum), 64'(0));
    chk("rst_lanes", lane_bus, 64'(0));
    send(8'd1, 8'd1, 0, 8);
    collect(5);
    send(8'hFF, 8'd0, 0, 8);
    collect(0);
    send(8'd10, 8'd10, 1, 8);
    collect(0);
    send(8'd7, 8'd3, 0, 3);
    pulse_rst();
    chk("fill_rst_lanes", lane_bus, 64'(0));
    chk("fill_rst_rdy", 64'(in_ready), 64'(1));
    send(8'd1, 8'd1, 0, 8);
    tick();
    tick();
    pulse_rst();
    void'(q.pop_back());
    chk("wait_rst_valid", 64'(out_valid), 64'(0));
    chk("wait_rst_sum", 64'(out_sum), 64'(0));
    chk("wait_rst_lanes", lane_bus, 64'(0));
    chk("wait_rst_rdy", 64'(in_ready), 64'(1));
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("no_result", 64'(out_valid), 64'(0));
    end
    send(8'd2, 8'd1, 0, 8);
    collect(0);
    rdy_def = 1;
    out_ready = 1;
    send(8'd0, 8'd0, 0, 8);
    collect(0);
    send(8'd1, 8'd0, 0, 8);
    chk("b2b_lanes", lane_bus, 64'h0101010101010101);
    collect(0);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
